// File: rtl/collision_checker.sv
// Tests a candidate tetromino placement (one box cell per cycle) against the
// fixed-cell board and the board edges, answering the control FSM's check handshake.
module collision_checker #(
  parameter int ROW = 10,
  parameter int COL = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               check_move,
  input  logic               check_down,
  input  logic [3:0]         action,
  input  logic [ROW*COL-1:0] board,
  input  logic [15:0]        cur_mask,
  input  logic [15:0]        rot_mask,
  input  logic [4:0]         cur_x,
  input  logic [4:0]         cur_y,
  output logic               busy,
  output logic               can_move,
  output logic               can_down,
  output logic               check_move_over,
  output logic               check_down_over
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic signed [5:0] COL_S = 6'(COL);
  localparam logic signed [5:0] ROW_S = 6'(ROW);

  state_t state, state_d;
  logic [3:0] idx, idx_d;
  logic       hit, hit_d;
  logic       busy_d, can_move_d, can_down_d, move_over_d, down_over_d;
  logic       accept;

  // Request snapshot: every check works only from these copies.
  logic               kind_down;
  logic [15:0]        mask_q;
  logic [ROW*COL-1:0] board_q;
  logic [5:0]         x_q, y_q, dx_q, dy_q;

  assign accept = (state == IDLE) && (check_down || check_move);

  // NOTE: the snapshot is pure datapath qualified by the FSM, so it carries no
  // reset; its contents are never observed before an accept overwrites them.
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_down <= check_down;
      board_q   <= board;
      x_q       <= {cur_x[4], cur_x};
      y_q       <= {cur_y[4], cur_y};
      mask_q    <= cur_mask;
      dx_q      <= 6'd0;
      dy_q      <= 6'd0;
      if (check_down) begin
        dy_q <= 6'd1;
      end else begin
        case (action)
          4'd1:    dx_q   <= 6'h3F;
          4'd2:    dx_q   <= 6'd1;
          4'd3:    mask_q <= rot_mask;
          4'd4:    dy_q   <= 6'd1;
          default: ;
        endcase
      end
    end
  end

  // Cell under test: 6-bit two's-complement position of box cell idx.
  logic [5:0]         col, row;
  logic               col_bad, row_bad, occupied, cell_hit;
  int                 cell_idx;
  logic [ROW*COL-1:0] shifted;

  always_comb begin
    col      = x_q + {4'b0, idx[1:0]} + dx_q;
    row      = y_q + {4'b0, idx[3:2]} + dy_q;
    col_bad  = col[5] || ($signed(col) >= COL_S);
    row_bad  = !row[5] && ($signed(row) >= ROW_S);
    cell_idx = int'($signed(row)) * COL + int'($signed(col));
    shifted  = board_q >> cell_idx;
    // Rows above the top edge are legal and never touch the board.
    occupied = !row[5] && shifted[0];
    cell_hit = mask_q[idx] && (col_bad || row_bad || occupied);
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    hit_d       = hit;
    busy_d      = busy;
    can_move_d  = can_move;
    can_down_d  = can_down;
    move_over_d = 1'b0;
    down_over_d = 1'b0;
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          state_d = SCAN;
          busy_d  = 1'b1;
          idx_d   = 4'd0;
          hit_d   = 1'b0;
        end
      end
      SCAN: begin
        hit_d = hit | cell_hit;
        idx_d = idx + 4'd1;
        if (idx == 4'd15) state_d = DONE;
      end
      DONE: begin
        // busy stays high through this cycle and drops on the next edge.
        state_d = IDLE;
        if (kind_down) begin
          can_down_d  = ~hit;
          down_over_d = 1'b1;
        end else begin
          can_move_d  = ~hit;
          move_over_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= 4'd0;
      hit             <= 1'b0;
      busy            <= 1'b0;
      can_move        <= 1'b0;
      can_down        <= 1'b0;
      check_move_over <= 1'b0;
      check_down_over <= 1'b0;
    end else begin
      state           <= state_d;
      idx             <= idx_d;
      hit             <= hit_d;
      busy            <= busy_d;
      can_move        <= can_move_d;
      can_down        <= can_down_d;
      check_move_over <= move_over_d;
      check_down_over <= down_over_d;
    end
  end

endmodule

// File: tb/tb_collision_checker.sv
// Directed, table-driven bench for collision_checker: result values, 17-cycle
// latency, busy window, strobe priority, ignored strobes and mid-check reset.
module tb_collision_checker;

  localparam int ROW = 10;
  localparam int COL = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               check_move, check_down;
  logic [3:0]         action;
  logic [ROW*COL-1:0] board;
  logic [15:0]        cur_mask, rot_mask;
  logic [4:0]         cur_x, cur_y;
  logic               busy, can_move, can_down, check_move_over, check_down_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_checker #(.ROW(ROW), .COL(COL)) dut (
    .clk             (clk),
    .rst             (rst),
    .check_move      (check_move),
    .check_down      (check_down),
    .action          (action),
    .board           (board),
    .cur_mask        (cur_mask),
    .rot_mask        (rot_mask),
    .cur_x           (cur_x),
    .cur_y           (cur_y),
    .busy            (busy),
    .can_move        (can_move),
    .can_down        (can_down),
    .check_move_over (check_move_over),
    .check_down_over (check_down_over)
  );

  typedef struct {
    logic               down;
    logic               move;
    logic [3:0]         action;
    logic [15:0]        mask;
    logic [15:0]        rot;
    logic [4:0]         x;
    logic [4:0]         y;
    logic [ROW*COL-1:0] board;
    logic               exp_move_over;
    logic               exp_down_over;
    logic               exp_can_move;
    logic               exp_can_down;
  } vec_t;

  localparam logic [ROW*COL-1:0] B_EMPTY = '0;
  localparam logic [ROW*COL-1:0] B_R6C3  = 80'(1) << (6*COL + 3);
  localparam logic [ROW*COL-1:0] B_R1C4  = 80'(1) << (1*COL + 4);

  vec_t vecs[15];

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one request, scrambles every input after the strobe edge, then
  // checks latency, result, pulse width and the busy window.
  task automatic run_check(input vec_t v, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    action     = v.action;
    cur_mask   = v.mask;
    rot_mask   = v.rot;
    cur_x      = v.x;
    cur_y      = v.y;
    board      = v.board;
    check_down = v.down;
    check_move = v.move;
    tick();
    check_down = 1'b0;
    check_move = 1'b0;
    board      = '1;
    cur_mask   = '1;
    rot_mask   = '1;
    cur_x      = 5'd0;
    cur_y      = 5'd0;
    check_bit({tag, "_busy_start"}, busy, 1'b1);
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (check_move_over || check_down_over) begin
        lat = n;
        break;
      end
    end
    check_int({tag, "_latency"}, lat, 17);
    check_bit({tag, "_move_over"}, check_move_over, v.exp_move_over);
    check_bit({tag, "_down_over"}, check_down_over, v.exp_down_over);
    check_bit({tag, "_can_move"}, can_move, v.exp_can_move);
    check_bit({tag, "_can_down"}, can_down, v.exp_can_down);
    check_bit({tag, "_busy_done"}, busy, 1'b1);
    tick();
    check_bit({tag, "_over_cleared"}, check_move_over | check_down_over, 1'b0);
    check_bit({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int mo_cnt, do_cnt;
    //         down  move  act    mask      rot       x      y      board    mo    do    cm    cd
    vecs[0]  = '{1'b0, 1'b1, 4'd1, 16'h0033, 16'h0000, 5'd0,  5'd0,  B_EMPTY, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd2, 16'h0033, 16'h0000, 5'd0,  5'd0,  B_EMPTY, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd2, 16'h000F, 16'h0000, 5'd4,  5'd5,  B_EMPTY, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'd2, 16'h000F, 16'h0000, 5'd3,  5'd5,  B_EMPTY, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'd0, 16'h0033, 16'h0000, 5'd2,  5'd8,  B_EMPTY, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'd0, 16'h0033, 16'h0000, 5'd2,  5'd7,  B_EMPTY, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 4'd0, 16'h0033, 16'h0000, 5'd2,  5'd4,  B_R6C3,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd3, 16'h0330, 16'h000F, 5'd2,  5'd4,  B_R6C3,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd0, 16'h0330, 16'h000F, 5'd2,  5'd4,  B_R6C3,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'd0, 16'h0033, 16'h0000, 5'd0,  5'h1E, B_EMPTY, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 4'd4, 16'h0033, 16'h0000, 5'd2,  5'd8,  B_EMPTY, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 4'd1, 16'h0000, 16'h0000, 5'd0,  5'd0,  B_EMPTY, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 4'd2, 16'h000F, 16'h0000, 5'd0,  5'd1,  B_R1C4,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 4'd1, 16'h0033, 16'h0000, 5'd2,  5'd7,  B_EMPTY, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 4'd1, 16'h0033, 16'h0000, 5'd1,  5'h1D, B_EMPTY, 1'b1, 1'b0, 1'b1, 1'b1};

    rst        = 1'b1;
    check_move = 1'b0;
    check_down = 1'b0;
    action     = 4'd0;
    board      = '0;
    cur_mask   = '0;
    rot_mask   = '0;
    cur_x      = 5'd0;
    cur_y      = 5'd0;
    repeat (2) tick();
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_can_move", can_move, 1'b0);
    check_bit("reset_can_down", can_down, 1'b0);
    check_bit("reset_move_over", check_move_over, 1'b0);
    check_bit("reset_down_over", check_down_over, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_check(vecs[i], $sformatf("v%0d", i));

    // A down strobe five edges into a move check must be dropped silently.
    @(negedge clk);
    action = 4'd2; cur_mask = 16'h0033; cur_x = 5'd0; cur_y = 5'd0; board = B_EMPTY;
    check_move = 1'b1;
    tick();
    check_move = 1'b0;
    repeat (4) tick();
    check_down = 1'b1;
    tick();
    check_down = 1'b0;
    mo_cnt = 0;
    do_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      if (check_move_over) mo_cnt++;
      if (check_down_over) do_cnt++;
      tick();
    end
    check_int("ignored_move_pulses", mo_cnt, 1);
    check_int("ignored_down_pulses", do_cnt, 0);
    check_bit("ignored_can_move", can_move, 1'b1);
    check_bit("ignored_can_down", can_down, 1'b1);

    // Reset sampled at strobe+8 aborts the check with no pulse.
    @(negedge clk);
    action = 4'd2; cur_mask = 16'h0033; cur_x = 5'd0; cur_y = 5'd0; board = B_EMPTY;
    check_move = 1'b1;
    tick();
    check_move = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_can_move", can_move, 1'b0);
    check_bit("midrst_can_down", can_down, 1'b0);
    check_bit("midrst_move_over", check_move_over, 1'b0);
    check_bit("midrst_down_over", check_down_over, 1'b0);
    rst = 1'b0;
    mo_cnt = 0;
    for (int n = 0; n < 25; n++) begin
      if (check_move_over || check_down_over) mo_cnt++;
      tick();
    end
    check_int("midrst_no_pulse", mo_cnt, 0);

    run_check('{1'b1, 1'b0, 4'd0, 16'h0033, 16'h0000, 5'd2, 5'd7, B_EMPTY, 1'b0, 1'b1, 1'b0, 1'b1},
              "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
